mips_mc_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS core. Sequences fetch, decode, execute, memory and writeback for each instruction, and drives the datapath muxes, register-file and PC enables, and the memory request handshake. Supplies the 2-bit ALUOp and a funct-source select to the ALU type decoder: ALUOp 00 = add, 01 = sub, 10 = decode the funct field.

---
 rtl/mips_mc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and decodes datapath controls from state, opcode, funct, zero and mem_ack.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       funct_sel,
  output logic       imm_zext,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_ITEXE  = 4'd9,
    S_ITWB   = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t r_state;
  state_t w_next;
  logic   w_is_itype;
  logic   w_is_shift;

  assign w_is_itype = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                      (opcode == OP_XORI) || (opcode == OP_SLTI);
  assign w_is_shift = (funct == 6'b000000) || (funct == 6'b000010) || (funct == 6'b000011);

  // State register; reset wins over any pending mem_ack, abandoning the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          w_next = S_RTEXE;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          w_next = S_MEMADR;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          w_next = S_BRANCH;
        end else if (opcode == OP_J) begin
          w_next = S_JUMP;
        end else if (w_is_itype) begin
          w_next = S_ITEXE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          w_next = S_MEMRD;
        end else if (opcode == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD:  w_next = mem_ack ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ack ? S_FETCH : S_MEMWR;
      S_RTEXE:  w_next = S_RTWB;
      S_RTWB:   w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ITEXE:  w_next = S_ITWB;
      S_ITWB:   w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode; everything is held at 0 while rst is asserted.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    funct_sel  = 1'b0;
    imm_zext   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state      = 4'd0;
    if (rst) begin
      state = 4'd0;
    end else begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ack;
          pc_write  = mem_ack;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = (w_next == S_FETCH);
        end
        S_MEMADR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ack;
        end
        S_RTEXE: begin
          alu_src_a = w_is_shift ? 2'b10 : 2'b01;
          alu_op    = 2'b10;
        end
        S_RTWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b01;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          pc_write   = (opcode == OP_BNE) ? ~zero : zero;
          instr_done = 1'b1;
        end
        S_ITEXE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
          funct_sel = 1'b1;
          imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        end
        S_ITWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          state = r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle vector table plus instruction latency sequences.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op;
  logic       funct_sel, imm_zext, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .funct_sel(funct_sel), .imm_zext(imm_zext), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  // Outputs packed as {state, req, we, iord, irw, pcw, pc_src, src_a, src_b, alu_op, fsel, zext, rw, rdst, m2r, done, ill}
  logic [23:0] act;
  assign act = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, funct_sel, imm_zext, reg_write, reg_dst, mem_to_reg,
                instr_done, illegal_op};

  function automatic logic [23:0] o(input logic [3:0] st, input logic req, we, iord, irw, pcw,
                                    input logic [1:0] psrc, asa, asb, aop,
                                    input logic fs, zx, rw, rd, m2r, dn, il);
    return {st, req, we, iord, irw, pcw, psrc, asa, asb, aop, fs, zx, rw, rd, m2r, dn, il};
  endfunction

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        a;
    logic [23:0] e;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic a, input logic [23:0] e);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.a = a; v.e = e;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  // Runs one instruction from FETCH, acking after the given wait counts; checks latency and handshake.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw, input int exp_cyc);
    int fcnt = 0;
    int mcnt = 0;
    int done_at = -1;
    int req_drop = 0;
    int we_bad = 0;
    opcode = op; funct = fn; zero = z;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (state == 4'd0) begin
        mem_ack = (fcnt >= fw); fcnt++;
      end else if (state == 4'd3 || state == 4'd5) begin
        mem_ack = (mcnt >= mw); mcnt++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if ((state == 4'd0 || state == 4'd3 || state == 4'd5) && !mem_req) req_drop++;
      if (mem_req && (mem_we != (state == 4'd5))) we_bad++;
      if (instr_done) begin
        done_at = cyc;
        break;
      end
    end
    check({name, "_latency"}, done_at, exp_cyc);
    check({name, "_handshake"}, req_drop + we_bad, 0);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  logic [23:0] FN, FA, DC, DI, MA, MR, MB, MW, MWD, RE, RS, RW, BT, BN, IZ, IS, IW, JP;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ORI = 6'b001101, ADDI = 6'b001000;
  localparam logic [5:0] ILL = 6'b111111, ADD = 6'b100000, SLL = 6'b000000;

  initial begin
    FN  = o(4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd1,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    FA  = o(4'd0, 1'b1,1'b0,1'b0,1'b1,1'b1, 2'd0,2'd0,2'd1,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    DC  = o(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    DI  = o(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1);
    MA  = o(4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    MR  = o(4'd3, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    MB  = o(4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0);
    MW  = o(4'd5, 1'b1,1'b1,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    MWD = o(4'd5, 1'b1,1'b1,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    RE  = o(4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd0,2'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    RS  = o(4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    RW  = o(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0);
    BT  = o(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1,2'd1,2'd0,2'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    BN  = o(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd1,2'd0,2'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    IZ  = o(4'd9, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd2, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0);
    IS  = o(4'd9, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd2, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    IW  = o(4'd10,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0);
    JP  = o(4'd11,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2,2'd0,2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);

    // reset, including an ack that must be ignored
    add(1'b1, R, ADD, 1'b0, 1'b0, 24'd0);
    add(1'b1, R, ADD, 1'b0, 1'b1, 24'd0);
    // add: ack on second FETCH cycle
    add(1'b0, R, ADD, 1'b0, 1'b0, FN);
    add(1'b0, R, ADD, 1'b0, 1'b1, FA);
    add(1'b0, R, ADD, 1'b0, 1'b0, DC);
    add(1'b0, R, ADD, 1'b0, 1'b0, RE);
    add(1'b0, R, ADD, 1'b0, 1'b0, RW);
    // lw: ack delayed 3 cycles in MEMRD
    add(1'b0, LW, ADD, 1'b0, 1'b1, FA);
    add(1'b0, LW, ADD, 1'b0, 1'b0, DC);
    add(1'b0, LW, ADD, 1'b0, 1'b0, MA);
    add(1'b0, LW, ADD, 1'b0, 1'b0, MR);
    add(1'b0, LW, ADD, 1'b0, 1'b0, MR);
    add(1'b0, LW, ADD, 1'b0, 1'b0, MR);
    add(1'b0, LW, ADD, 1'b0, 1'b1, MR);
    add(1'b0, LW, ADD, 1'b0, 1'b0, MB);
    // beq taken, bne not taken, bne taken
    add(1'b0, BEQ, ADD, 1'b1, 1'b1, FA);
    add(1'b0, BEQ, ADD, 1'b1, 1'b0, DC);
    add(1'b0, BEQ, ADD, 1'b1, 1'b0, BT);
    add(1'b0, BNE, ADD, 1'b1, 1'b1, FA);
    add(1'b0, BNE, ADD, 1'b1, 1'b0, DC);
    add(1'b0, BNE, ADD, 1'b1, 1'b0, BN);
    add(1'b0, BNE, ADD, 1'b0, 1'b1, FA);
    add(1'b0, BNE, ADD, 1'b0, 1'b0, DC);
    add(1'b0, BNE, ADD, 1'b0, 1'b0, BT);
    // sll, ori, addi, j
    add(1'b0, R, SLL, 1'b0, 1'b1, FA);
    add(1'b0, R, SLL, 1'b0, 1'b0, DC);
    add(1'b0, R, SLL, 1'b0, 1'b0, RS);
    add(1'b0, R, SLL, 1'b0, 1'b0, RW);
    add(1'b0, ORI, ADD, 1'b0, 1'b1, FA);
    add(1'b0, ORI, ADD, 1'b0, 1'b0, DC);
    add(1'b0, ORI, ADD, 1'b0, 1'b0, IZ);
    add(1'b0, ORI, ADD, 1'b0, 1'b0, IW);
    add(1'b0, ADDI, ADD, 1'b0, 1'b1, FA);
    add(1'b0, ADDI, ADD, 1'b0, 1'b0, DC);
    add(1'b0, ADDI, ADD, 1'b0, 1'b0, IS);
    add(1'b0, ADDI, ADD, 1'b0, 1'b0, IW);
    add(1'b0, J, ADD, 1'b0, 1'b1, FA);
    add(1'b0, J, ADD, 1'b0, 1'b0, DC);
    add(1'b0, J, ADD, 1'b0, 1'b0, JP);
    // illegal opcode
    add(1'b0, ILL, ADD, 1'b0, 1'b1, FA);
    add(1'b0, ILL, ADD, 1'b0, 1'b0, DI);
    add(1'b0, ILL, ADD, 1'b0, 1'b0, FN);
    // sw interrupted by reset mid-wait, late ack ignored, then a clean sw
    add(1'b0, SW, ADD, 1'b0, 1'b1, FA);
    add(1'b0, SW, ADD, 1'b0, 1'b0, DC);
    add(1'b0, SW, ADD, 1'b0, 1'b0, MA);
    add(1'b0, SW, ADD, 1'b0, 1'b0, MW);
    add(1'b0, SW, ADD, 1'b0, 1'b0, MW);
    add(1'b1, SW, ADD, 1'b0, 1'b0, 24'd0);
    add(1'b1, SW, ADD, 1'b0, 1'b1, 24'd0);
    add(1'b0, SW, ADD, 1'b0, 1'b0, FN);
    add(1'b0, SW, ADD, 1'b0, 1'b1, FA);
    add(1'b0, SW, ADD, 1'b0, 1'b0, DC);
    add(1'b0, SW, ADD, 1'b0, 1'b0, MA);
    add(1'b0, SW, ADD, 1'b0, 1'b1, MWD);
    add(1'b0, SW, ADD, 1'b0, 1'b0, FN);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].r; opcode = vt[i].op; funct = vt[i].fn; zero = vt[i].z; mem_ack = vt[i].a;
      #1;
      checks++;
      if (act !== vt[i].e) begin
        errors++;
        $display("FAIL vec%0d: outputs got %h expected %h", i, act, vt[i].e);
      end
    end
    mem_ack = 1'b0;

    // latency sequences, each starting in FETCH
    run_instr("rtype",  R,   ADD, 1'b0, 0, 0, 4);
    run_instr("lw_w3",  LW,  ADD, 1'b0, 0, 3, 8);
    run_instr("sw_w21", SW,  ADD, 1'b0, 2, 1, 7);
    run_instr("beq",    BEQ, ADD, 1'b1, 0, 0, 3);
    run_instr("j_w1",   J,   ADD, 1'b0, 1, 0, 4);
    run_instr("ori",    ORI, ADD, 1'b0, 0, 0, 4);
    run_instr("lw_w0",  LW,  ADD, 1'b0, 0, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
